iopad_xfer: RTL and testbench
=============================

IOPAD_XFER -- requirements
Module: iopad_xfer

Interface
REQ-001 SHALL have parameter DW, default 8; data word width in bits.
REQ-002 SHALL have parameter DIV, default 4; clk cycles per pad bit, legal range 2..255.
REQ-003 SHALL have parameter TURN, default 2; idle cycles after the TX stop bit, with pad_dout_en low, before RX starts.
REQ-004 SHALL have parameter TMO, default 64; maximum cycles to wait for the RX start bit.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, with all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1 bit; the core has a transfer request.
REQ-008 SHALL have port req_ready, output, 1 bit; the block accepts a request this cycle.
REQ-009 SHALL have port req_data, input, DW bits; the word to transmit.
REQ-010 SHALL have port req_rd, input, 1 bit; a response word is expected after TX.
REQ-011 SHALL have port rsp_valid, output, 1 bit; a one-cycle pulse marking the response.
REQ-012 SHALL have port rsp_data, output, DW bits; the received word.
REQ-013 SHALL have port rsp_err, output, 1 bit; the response failed (timeout, framing or parity).
REQ-014 SHALL have port pad_dout, output, 1 bit; the serial value driven to the pad.
REQ-015 SHALL have port pad_dout_en, output, 1 bit; the pad output enable.
REQ-016 SHALL have port pad_din, input, 1 bit; the serial value sampled from the pad, asynchronous to clk.
REQ-017 SHALL have port busy, output, 1 bit; high whenever the state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, TX_START, TX_DATA, TX_STOP, TURN, RX_WAIT, RX_DATA, RX_STOP and DONE.
REQ-019 SHALL assert req_ready only in IDLE; a handshake is req_valid && req_ready, and on it the block latches req_data and req_rd and moves to TX_START.
REQ-020 SHALL, in TX_START, drive pad_dout=0 and pad_dout_en=1 for DIV cycles.
REQ-021 SHALL, in TX_DATA, send DW bits LSB first, each held DIV cycles.
REQ-022 SHALL, in TX_STOP, drive pad_dout=1 for DIV cycles.
REQ-023 SHALL, after TX_STOP, go to IDLE when req_rd=0 and to TURN when req_rd=1.
REQ-024 SHALL hold pad_dout_en=0 in TURN, RX_WAIT, RX_DATA, RX_STOP, DONE and IDLE; pad_dout=1 in IDLE.
REQ-025 SHALL pass pad_din through a 2-flop synchronizer, and all RX decisions SHALL use the synchronized value.
REQ-026 SHALL, in RX_WAIT, count cycles and enter RX_DATA on the first synchronized low; if TMO cycles elapse first, it SHALL enter DONE with rsp_err=1 and rsp_data=0.
REQ-027 SHALL, in RX_DATA, sample each bit at count DIV/2 within its bit period, LSB first, for DW bits.
REQ-028 SHALL, in RX_STOP, sample at mid-bit; a 0 SHALL set rsp_err=1.
REQ-029 SHALL, in DONE, pulse rsp_valid for exactly 1 cycle and then return to IDLE; rsp_data and rsp_err SHALL hold until the next rsp_valid.
REQ-030 SHALL ignore req_valid while busy=1; there SHALL be no request queueing.
REQ-031 SHALL use bit counters of width clog2(DIV) and clog2(DW+1); the TMO counter SHALL saturate and never wrap.

Reset
REQ-032 SHALL, on rst, immediately and asynchronously set: state=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_err=0, pad_dout=1, pad_dout_en=0, counters=0, synchronizer flops=1.
REQ-033 SHALL, when rst is asserted mid-transfer, abort the transfer with no rsp_valid, and the pad SHALL release within 0 clk cycles of reset assertion.

Configuration
REQ-034 SHALL support macro IOPAD_XFER_PARITY_EN: when defined, one even-parity bit SHALL follow the data in TX and in RX, and an RX parity mismatch SHALL set rsp_err=1.
REQ-035 SHALL, without IOPAD_XFER_PARITY_EN, have no parity bit in either direction, and the frame SHALL be start + DW + stop.

Structure
REQ-036 SHALL place the state enum typedef and the default DW/DIV/TURN/TMO constants in shared package iopad_pkg.
REQ-037 SHALL implement the synchronizer as sub-module iopad_sync, with ports clk, rst, d, q and reset value 1.

Verification
REQ-038 SHALL test: req_data=0xA5, req_rd=0, DIV=4 -> pad sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; pad_dout_en high 40 cycles; no rsp_valid.
REQ-039 SHALL test: req_rd=1 with the bench answering 0x3C after TURN -> rsp_valid one pulse, rsp_data=0x3C, rsp_err=0.
REQ-040 SHALL test: req_rd=1 with pad_din held 1 -> rsp_valid exactly TMO cycles after RX_WAIT entry, rsp_err=1, rsp_data=0.
REQ-041 SHALL test: the bench answers 0x3C with stop bit 0 -> rsp_err=1.
REQ-042 SHALL test: rst asserted mid-TX_DATA -> pad_dout_en=0 and busy=0 immediately, no rsp_valid, and a fresh request completes normally.
REQ-043 SHALL test, with IOPAD_XFER_PARITY_EN: TX of 0x07 -> parity bit 1; an RX word with a wrong parity bit -> rsp_err=1.

Source files
------------

// File: rtl/iopad_pkg.sv
// Shared definitions for the serial pad transfer block: FSM state encoding,
// default configuration constants and a small sizing helper.
package iopad_pkg;

  localparam int DW_DEF   = 8;
  localparam int DIV_DEF  = 4;
  localparam int TURN_DEF = 2;
  localparam int TMO_DEF  = 64;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP,
    S_TURN,
    S_RX_WAIT,
    S_RX_DATA,
    S_RX_STOP,
    S_DONE
  } state_t;

  // Larger of two integers, used to size the shared wait counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iopad_sync.sv
// Two-flop synchronizer for the asynchronous pad input. Both flops reset to 1
// so an idle (high) line never looks like a start bit after reset.
module iopad_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  // Double-register the pad value into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b1;
      q        <= 1'b1;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/iopad_xfer.sv
// Half-duplex serial pad transfer engine. Sends start + DW data bits (LSB
// first) + stop, then optionally turns the line around and receives a word
// framed the same way. Optional feature macro: IOPAD_XFER_PARITY_EN adds one
// even-parity bit after the data in both directions.
module iopad_xfer
  import iopad_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int DIV  = DIV_DEF,
  parameter int TURN = TURN_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_data,
  input  logic          req_rd,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          pad_dout,
  output logic          pad_dout_en,
  input  logic          pad_din,
  output logic          busy
);

`ifdef IOPAD_XFER_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  localparam int DCW = $clog2(DIV);
  localparam int BCW = $clog2(DW + 1);
  localparam int WCW = $clog2(max_int(TMO, TURN) + 1);

  localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
  localparam logic [DCW-1:0] DIV_MID   = DCW'(DIV / 2);
  localparam logic [DCW-1:0] DIV_ONE   = DCW'(1);
  localparam logic [BCW-1:0] NB_LAST   = BCW'(NB - 1);
  localparam logic [WCW-1:0] TURN_LAST = WCW'(TURN - 1);
  localparam logic [WCW-1:0] TMO_LAST  = WCW'(TMO - 1);
  localparam logic [WCW-1:0] TMO_MAX   = WCW'(TMO);

  state_t          state_reg, state_next;
  logic [DCW-1:0]  div_cnt_reg, div_cnt_next;
  logic [BCW-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WCW-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [NB-1:0]   tx_shift_reg, tx_shift_next;
  logic [NB-1:0]   rx_shift_reg, rx_shift_next;
  logic            rd_reg, rd_next;
  logic            skip_reg, skip_next;
  logic [DW-1:0]   rsp_data_reg, rsp_data_next;
  logic            rsp_err_reg, rsp_err_next;
  logic            sync_din;
  logic [NB-1:0]   tx_frame;
  logic            par_err;

  iopad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_din),
    .q   (sync_din)
  );

  // Build the outgoing data/parity word and check the incoming one.
  always_comb begin
`ifdef IOPAD_XFER_PARITY_EN
    tx_frame = {^req_data, req_data};
    par_err  = ^rx_shift_reg;
`else
    tx_frame = req_data;
    par_err  = 1'b0;
`endif
  end

  // State and datapath registers; reset releases the pad immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rd_reg       <= 1'b0;
      skip_reg     <= 1'b0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rd_reg       <= rd_next;
      skip_reg     <= skip_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  // Next-state logic: bit timing, framing and response capture.
  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = div_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rd_next       = rd_reg;
    skip_next     = skip_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          tx_shift_next = tx_frame;
          rd_next       = req_rd;
          div_cnt_next  = '0;
          state_next    = S_TX_START;
        end
      end
      S_TX_START: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = S_TX_DATA;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      S_TX_DATA: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next  = '0;
          tx_shift_next = {1'b1, tx_shift_reg[NB-1:1]};
          if (bit_cnt_reg == NB_LAST) begin
            state_next = S_TX_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      S_TX_STOP: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next  = '0;
          wait_cnt_next = '0;
          state_next    = rd_reg ? S_TURN : S_IDLE;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      S_TURN: begin
        if (wait_cnt_reg == TURN_LAST) begin
          wait_cnt_next = '0;
          state_next    = S_RX_WAIT;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      S_RX_WAIT: begin
        if (!sync_din) begin
          // The detection cycle is count 0 of the start bit; the first
          // RX_DATA period finishes off the start bit before data begins.
          div_cnt_next = DIV_ONE;
          bit_cnt_next = '0;
          skip_next    = 1'b1;
          state_next   = S_RX_DATA;
        end else if (wait_cnt_reg == TMO_LAST) begin
          rsp_data_next = '0;
          rsp_err_next  = 1'b1;
          state_next    = S_DONE;
        end else if (wait_cnt_reg != TMO_MAX) begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      S_RX_DATA: begin
        if (!skip_reg && div_cnt_reg == DIV_MID) begin
          rx_shift_next = {sync_din, rx_shift_reg[NB-1:1]};
        end
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          if (skip_reg) begin
            skip_next = 1'b0;
          end else if (bit_cnt_reg == NB_LAST) begin
            state_next = S_RX_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      S_RX_STOP: begin
        if (div_cnt_reg == DIV_MID) begin
          rsp_data_next = rx_shift_reg[DW-1:0];
          rsp_err_next  = !sync_din || par_err;
          div_cnt_next  = '0;
          state_next    = S_DONE;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state so reset releases the pad with no clock edge.
  always_comb begin
    req_ready   = (state_reg == S_IDLE);
    busy        = (state_reg != S_IDLE);
    rsp_valid   = (state_reg == S_DONE);
    rsp_data    = rsp_data_reg;
    rsp_err     = rsp_err_reg;
    pad_dout_en = 1'b0;
    pad_dout    = 1'b1;
    case (state_reg)
      S_TX_START: begin
        pad_dout_en = 1'b1;
        pad_dout    = 1'b0;
      end
      S_TX_DATA: begin
        pad_dout_en = 1'b1;
        pad_dout    = tx_shift_reg[0];
      end
      S_TX_STOP: begin
        pad_dout_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iopad_xfer.sv
// Self-checking bench for iopad_xfer: table of directed transfers, reset
// abort sequence, optional parity sequences and randomized transfers scored
// against a frame-level model of the pad protocol.
module tb_iopad_xfer;

  localparam int DW   = 8;
  localparam int DIV  = 4;
  localparam int TURN = 2;
  localparam int TMO  = 64;
`ifdef IOPAD_XFER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_data;
  logic          req_rd;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          pad_dout;
  logic          pad_dout_en;
  logic          pad_din;
  logic          busy;

  iopad_xfer #(.DW(DW), .DIV(DIV), .TURN(TURN), .TMO(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_rd      (req_rd),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .pad_dout    (pad_dout),
    .pad_dout_en (pad_dout_en),
    .pad_din     (pad_din),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          rd;
    int            kind;      // 0: bench answers, 1: bench stays silent
    logic [DW-1:0] resp;
    logic          stop_bit;
    logic          par_flip;
    int            gap;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            pulses;
  int            first_valid;
  int            cyc;
  logic [DW-1:0] got_data;
  logic          got_err;
  logic [DW-1:0] last_data;
  logic          last_err;
  logic          cap_q[$];
  vec_t          tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample the response outputs for this cycle, then step to 1 after the next edge.
  task automatic tick();
    if (rsp_valid === 1'b1) begin
      if (pulses == 0) first_valid = cyc;
      pulses++;
      got_data = rsp_data;
      got_err  = rsp_err;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_xfer(input string name, input logic [DW-1:0] data, input logic rd,
                         input int kind, input logic [DW-1:0] resp, input logic stop_bit,
                         input logic par_flip, input int gap,
                         input logic [DW-1:0] exp_data, input logic exp_err);
    logic frame[$];
    logic exp_q[$];
    logic rxf[$];
    int   n;
    int   bad_bits;
    logic bz;
    // expected pad waveform from the frame definition
    frame.push_back(1'b0);
    for (int i = 0; i < DW; i++) frame.push_back(data[i]);
    if (PAR == 1) frame.push_back(^data);
    frame.push_back(1'b1);
    foreach (frame[i]) for (int k = 0; k < DIV; k++) exp_q.push_back(frame[i]);

    check({name, ".hold_data"}, rsp_data, last_data);
    check({name, ".hold_err"}, rsp_err, last_err);
    got_data = '0;
    got_err  = 1'b0;

    @(negedge clk);
    req_valid = 1'b1;
    req_data  = data;
    req_rd    = rd;
    check({name, ".ready_idle"}, req_ready, 1);
    @(posedge clk);
    #1;
    // change inputs after the handshake: the block must have latched them
    req_data = ~data;
    req_rd   = ~rd;
    pulses = 0;
    cyc    = 0;
    cap_q.delete();
    n  = 0;
    bz = 1'b0;
    while (pad_dout_en === 1'b1 && n < 1000) begin
      cap_q.push_back(pad_dout);
      if (busy !== 1'b1 || req_ready !== 1'b0) bz = 1'b1;
      n++;
      if (n == 3) req_valid = 1'b0;
      tick();
    end
    req_valid = 1'b0;
    check({name, ".tx_len"}, cap_q.size(), exp_q.size());
    bad_bits = 0;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) bad_bits++;
    check({name, ".tx_bits"}, bad_bits, 0);
    check({name, ".busy_tx"}, bz, 0);
    check({name, ".tx_no_rsp"}, pulses, 0);

    cyc    = 0;
    pulses = 0;
    if (!rd) begin
      repeat (20) tick();
      check({name, ".no_rsp"}, pulses, 0);
    end else if (kind == 1) begin
      repeat (TURN + TMO + 20) tick();
      check({name, ".tmo_pulses"}, pulses, 1);
      check({name, ".tmo_cycles"}, first_valid, TURN + TMO);
    end else begin
      rxf.push_back(1'b0);
      for (int i = 0; i < DW; i++) rxf.push_back(resp[i]);
      if (PAR == 1) rxf.push_back((^resp) ^ par_flip);
      rxf.push_back(stop_bit);
      repeat (TURN + gap) tick();
      foreach (rxf[i]) begin
        pad_din = rxf[i];
        repeat (DIV) tick();
      end
      pad_din = 1'b1;
      repeat (40) tick();
      check({name, ".rsp_pulses"}, pulses, 1);
    end
    if (rd) begin
      check({name, ".rsp_data"}, got_data, exp_data);
      check({name, ".rsp_err"}, got_err, exp_err);
      last_data = exp_data;
      last_err  = exp_err;
    end
    check({name, ".idle_end"}, busy, 0);
    $display("xfer %s: data=%h rd=%b kind=%0d resp=%h stop=%b pflip=%b gap=%0d -> pulses=%0d rsp_data=%h rsp_err=%b",
             name, data, rd, kind, resp, stop_bit, par_flip, gap, pulses, got_data, got_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{data: 8'hA5, rd: 1'b0, kind: 0, resp: 8'h00, stop_bit: 1'b1, par_flip: 1'b0, gap: 0, exp_data: 8'h00, exp_err: 1'b0};
    tbl[1] = '{data: 8'h3C, rd: 1'b1, kind: 0, resp: 8'h3C, stop_bit: 1'b1, par_flip: 1'b0, gap: 0, exp_data: 8'h3C, exp_err: 1'b0};
    tbl[2] = '{data: 8'h81, rd: 1'b1, kind: 1, resp: 8'h00, stop_bit: 1'b1, par_flip: 1'b0, gap: 0, exp_data: 8'h00, exp_err: 1'b1};
    tbl[3] = '{data: 8'h5A, rd: 1'b1, kind: 0, resp: 8'h3C, stop_bit: 1'b0, par_flip: 1'b0, gap: 3, exp_data: 8'h3C, exp_err: 1'b1};
    tbl[4] = '{data: 8'hC3, rd: 1'b1, kind: 0, resp: 8'h96, stop_bit: 1'b1, par_flip: 1'b0, gap: 7, exp_data: 8'h96, exp_err: 1'b0};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    req_rd    = 1'b0;
    pad_din   = 1'b1;
    last_data = '0;
    last_err  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset.ready", req_ready, 1);
    check("reset.busy", busy, 0);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.rsp_data", rsp_data, 0);
    check("reset.rsp_err", rsp_err, 0);
    check("reset.pad_dout", pad_dout, 1);
    check("reset.pad_en", pad_dout_en, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      do_xfer($sformatf("tbl%0d", i), tbl[i].data, tbl[i].rd, tbl[i].kind, tbl[i].resp,
              tbl[i].stop_bit, tbl[i].par_flip, tbl[i].gap, tbl[i].exp_data, tbl[i].exp_err);

    // reset in the middle of TX_DATA aborts the transfer and frees the pad at once
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 8'h5A;
    req_rd    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (DIV * 3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort.pad_en", pad_dout_en, 0);
    check("abort.busy", busy, 0);
    check("abort.pad_dout", pad_dout, 1);
    check("abort.rsp_valid", rsp_valid, 0);
    last_data = '0;
    last_err  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    pulses = 0;
    cyc    = 0;
    repeat (100) tick();
    check("abort.no_rsp", pulses, 0);
    $display("xfer abort: reset during TX_DATA, pulses afterwards=%0d", pulses);
    do_xfer("after_abort", 8'h69, 1'b1, 0, 8'hE1, 1'b1, 1'b0, 2, 8'hE1, 1'b0);

`ifdef IOPAD_XFER_PARITY_EN
    do_xfer("par_tx07", 8'h07, 1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    if (cap_q.size() > (1 + DW) * DIV + DIV / 2)
      check("par_tx07.par_bit", cap_q[(1 + DW) * DIV + DIV / 2], 1);
    else
      check("par_tx07.par_len", cap_q.size(), (3 + DW) * DIV);
    do_xfer("par_rx_bad", 8'h11, 1'b1, 0, 8'h55, 1'b1, 1'b1, 1, 8'h55, 1'b1);
    do_xfer("par_rx_good", 8'h11, 1'b1, 0, 8'h57, 1'b1, 1'b0, 1, 8'h57, 1'b0);
`endif

    for (int i = 0; i < 12; i++) begin
      logic [DW-1:0] d;
      logic [DW-1:0] r;
      logic          rd;
      logic          stop_b;
      logic          pflip;
      int            kind;
      int            gap;
      d      = DW'($urandom);
      r      = DW'($urandom);
      rd     = 1'($urandom_range(0, 1));
      kind   = ($urandom_range(0, 5) == 0) ? 1 : 0;
      stop_b = ($urandom_range(0, 4) != 0);
      pflip  = (PAR == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      gap    = $urandom_range(0, 20);
      do_xfer($sformatf("rnd%0d", i), d, rd, kind, r, stop_b, pflip, gap,
              (kind == 1) ? '0 : r, (kind == 1) ? 1'b1 : (!stop_b || pflip));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
